sevseg_scan_driver: RTL and testbench
=====================================

Name: sevseg_scan_driver

Overview:
Time-multiplexed driver for a bank of DIGITS common-anode seven-segment digits.
- Latches a packed nibble vector and scans one digit per refresh slot.
- Decodes each nibble in decimal mode (10–15 blank) or hex mode (A–F glyphs).
- Inserts a guard interval per slot to suppress ghosting.
- Sits between the processor's debug/output register and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned (1–8)
REFRESH_DIV, 100000, clock cycles per digit slot (≥2)
GUARD, 16, cycles at slot start with all anodes off (0 ≤ GUARD < REFRESH_DIV)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
value  input  4*DIGITS  packed nibbles; digit i = value[4i+3:4i], digit 0 rightmost
load  input  1  capture value into shadow register
hex_mode  input  1  1 = hex glyphs, 0 = decimal (nibble ≥10 blank)
blank  input  1  1 = display fully off
dp  input  DIGITS  decimal point request per digit, active-high
seg  output  7  segments a..g on seg[6]..seg[0], active-low, registered
dp_n  output  1  decimal point, active-low, registered
an  output  DIGITS  anode enables, active-low, one-hot-low when lit, registered

Behaviour:
- Reset: shadow=0, cnt=0, idx=0, an=all 1, seg=7'h7F, dp_n=1.
- Reset mid-scan takes effect on the next edge with the same values as above.
- Reset has priority over load.
- Shadow register:
  - load=1 at edge k → shadow=value at edge k.
  - value is ignored while load=0.
  - dp is sampled live, not shadowed.
- Slot counter:
  - cnt increments every cycle.
  - At cnt==REFRESH_DIV-1: cnt→0 and idx→(idx+1) mod DIGITS.
  - idx DIGITS-1 wraps to 0.
- Output register (updated every edge from the current cnt/idx/shadow/inputs; 1-cycle latency):
  - blank=1 → an=all 1, seg=7'h7F, dp_n=1.
  - else if cnt<GUARD → an=all 1, seg=7'h7F, dp_n=1 (guard).
  - else → an = all 1 except bit idx=0; seg=glyph(shadow digit idx); dp_n=~dp[idx].
- load and slot change at the same edge: the new shadow is used from the following edge onward.
- Glyphs (active-low, a..g):
  - 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F, 8=00, 9=04
  - A=08, b=60, C=31, d=42, E=30, F=38
- Decimal mode: nibbles 10–15 → 7'h7F (blank) and dp still honoured.
- Each digit's lit time is REFRESH_DIV-GUARD cycles per frame.
- Frame length is DIGITS*REFRESH_DIV cycles.
- DIGITS=1: idx is constant 0 and the guard still applies each slot.

Optional Feature:
SEVSEG_LZS_EN — leading-zero suppression.
- Defined:
  - Digit i is blanked (seg=7'h7F, anode still driven for uniform brightness) when shadow digits DIGITS-1..i are all zero and i>0.
  - Digit 0 is never suppressed.
  - dp_n still follows dp[i].
  - Suppression is computed from shadow and has the same 1-cycle latency.
- Undefined: all digits are displayed, including leading zeros.

Test Plan:
Bench configuration for all scenarios: DIGITS=4, REFRESH_DIV=8, GUARD=2.
1. Reset asserted 3 cycles, then released → an=4'hF, seg=7'h7F, dp_n=1 at release; an=4'hE first appears at the output edge after cnt=2, i.e. 3rd edge after release.
2. load=1 with value=16'h1234, hex_mode=0 → over one 32-cycle frame, digit 0 shows 4C, digit 1 shows 06, digit 2 shows 12, digit 3 shows 4F; an sequence E,D,B,7, each low for 6 cycles separated by 2 cycles of F.
3. value=16'hAB0F, hex_mode=1 vs 0 → hex: F=38, 0=01, b=60, A=08; decimal: 7F, 01, 7F, 7F.
4. blank=1 asserted mid-slot → the next edge gives an=4'hF, seg=7'h7F; deassert → scanning resumes at the current cnt/idx without restarting.
5. load at the edge where cnt=7 with new value 16'h5555 → the next slot's digit shows 24 (new value), never the stale glyph after the load edge+1.
6. With SEVSEG_LZS_EN defined, value=16'h0070 → digits 3 and 2 give seg=7'h7F, digit 1=0F, digit 0=01; value=16'h0000 → only digit 0 shows 01.

Source files
------------

// File: rtl/sevseg_scan_if.sv
// Display bus of sevseg_scan_driver: value/control from the host register, segment and anode pins to the board.
interface sevseg_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic                hex_mode;
  logic                blank;
  logic [DIGITS-1:0]   dp;
  logic [6:0]          seg;
  logic                dp_n;
  logic [DIGITS-1:0]   an;

  modport master (
    output value, load, hex_mode, blank, dp,
    input  seg, dp_n, an
  );

  modport slave (
    input  value, load, hex_mode, blank, dp,
    output seg, dp_n, an
  );
endinterface

// File: rtl/sevseg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with per-slot guard interval.
// Optional leading-zero suppression is enabled by defining SEVSEG_LZS_EN.
module sevseg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic         clk,
  input  logic         reset,
  sevseg_scan_if.slave bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  logic [4*DIGITS-1:0] shadow;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;

  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_lz;
  logic [DIGITS-1:0]   an_next;
  logic [DIGITS-1:0]   lz_mask;

  // Active-low a..g glyphs; in decimal mode 10..15 render as blank.
  function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h01;
      4'h1:    g = 7'h4F;
      4'h2:    g = 7'h12;
      4'h3:    g = 7'h06;
      4'h4:    g = 7'h4C;
      4'h5:    g = 7'h24;
      4'h6:    g = 7'h20;
      4'h7:    g = 7'h0F;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h04;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h60;
      4'hC:    g = 7'h31;
      4'hD:    g = 7'h42;
      4'hE:    g = 7'h30;
      default: g = 7'h38;
    endcase
    if (!hex && nib >= 4'd10) g = SEG_OFF;
    return g;
  endfunction

  // Select the active digit's nibble, dp request and suppression flag.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    an_next = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib    = shadow[4*i +: 4];
        cur_dp     = bus.dp[i];
        cur_lz     = lz_mask[i];
        an_next[i] = 1'b0;
      end
    end
  end

`ifdef SEVSEG_LZS_EN
  // Digit i>0 is suppressed while it and every digit above it are zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above & (shadow[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_above;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      shadow <= '0;
    end else if (bus.load) begin
      shadow <= bus.value;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Outputs are built from the pre-edge slot state, giving one cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.an   <= '1;
      bus.seg  <= SEG_OFF;
      bus.dp_n <= 1'b1;
    end else if (bus.blank || cnt < CW'(GUARD)) begin
      bus.an   <= '1;
      bus.seg  <= SEG_OFF;
      bus.dp_n <= 1'b1;
    end else begin
      bus.an   <= an_next;
      bus.seg  <= cur_lz ? SEG_OFF : glyph(cur_nib, bus.hex_mode);
      bus.dp_n <= ~cur_dp;
    end
  end

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Directed bench for sevseg_scan_driver: per-cycle scoreboard against a reference model plus frame-level glyph checks.
module tb_sevseg_scan_driver;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 8;
  localparam int GUARD       = 2;
  localparam int FRAME       = DIGITS * REFRESH_DIV;

  localparam logic [6:0] GLYPHS [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
  } out_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sevseg_scan_if #(.DIGITS(DIGITS)) bus ();

  sevseg_scan_driver #(
    .DIGITS(DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .GUARD(GUARD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  out_t        exp_q [$];
  logic [15:0] m_shadow;
  int          m_cnt;
  int          m_idx;

  logic [6:0]  seen_seg [DIGITS];
  int          lit_cnt  [DIGITS];
  int          dark_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic out_t model_out();
    out_t        o;
    logic [15:0] sh;
    logic [3:0]  nib;
    o = '{an: 4'hF, seg: 7'h7F, dp_n: 1'b1};
    if (!reset && !bus.blank && m_cnt >= GUARD) begin
      sh       = m_shadow >> (4 * m_idx);
      nib      = sh[3:0];
      o.an[m_idx] = 1'b0;
      o.seg    = (!bus.hex_mode && nib >= 4'd10) ? 7'h7F : GLYPHS[nib];
`ifdef SEVSEG_LZS_EN
      if (m_idx > 0 && sh == 16'h0) o.seg = 7'h7F;
`endif
      o.dp_n   = ~bus.dp[m_idx];
    end
    return o;
  endfunction

  // One clock: push the expected output, advance the model, then compare after the edge.
  task automatic tick(input string tag);
    out_t obs;
    out_t exp;
    exp_q.push_back(model_out());
    if (reset) begin
      m_shadow = 16'h0;
      m_cnt    = 0;
      m_idx    = 0;
    end else begin
      if (bus.load) m_shadow = bus.value;
      if (m_cnt == REFRESH_DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % DIGITS;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    obs = '{an: bus.an, seg: bus.seg, dp_n: bus.dp_n};
    exp = exp_q.pop_front();
    check(tag, 32'(obs), 32'(exp));
  endtask

  task automatic run_frame(input string tag);
    for (int d = 0; d < DIGITS; d++) begin
      seen_seg[d] = 7'hxx;
      lit_cnt[d]  = 0;
    end
    dark_cnt = 0;
    for (int c = 0; c < FRAME; c++) begin
      tick(tag);
      if (bus.an == 4'hF) dark_cnt++;
      for (int d = 0; d < DIGITS; d++) begin
        if (bus.an == ~(4'b0001 << d)) begin
          seen_seg[d] = bus.seg;
          lit_cnt[d]++;
        end
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [6:0] d0, input logic [6:0] d1,
                             input logic [6:0] d2, input logic [6:0] d3);
    check({tag, "_d0"}, 32'(seen_seg[0]), 32'(d0));
    check({tag, "_d1"}, 32'(seen_seg[1]), 32'(d1));
    check({tag, "_d2"}, 32'(seen_seg[2]), 32'(d2));
    check({tag, "_d3"}, 32'(seen_seg[3]), 32'(d3));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_shadow     = 16'h0;
    m_cnt        = 0;
    m_idx        = 0;
    reset        = 1'b1;
    bus.value    = 16'h0;
    bus.load     = 1'b0;
    bus.hex_mode = 1'b0;
    bus.blank    = 1'b0;
    bus.dp       = 4'h0;

    // 1. Reset for 3 cycles, release, first lit anode on the 3rd edge.
    for (int i = 0; i < 3; i++) tick("reset");
    check("rst_an", 32'(bus.an), 32'h0F);
    check("rst_seg", 32'(bus.seg), 32'h7F);
    check("rst_dp_n", 32'(bus.dp_n), 32'h1);
    reset = 1'b0;
    tick("post_rst1");
    check("guard_edge1_an", 32'(bus.an), 32'h0F);
    tick("post_rst2");
    check("guard_edge2_an", 32'(bus.an), 32'h0F);
    tick("post_rst3");
    check("first_lit_an", 32'(bus.an), 32'h0E);
    check("first_lit_seg", 32'(bus.seg), 32'h01);

    // 2. Decimal 1234 over one frame.
    bus.value = 16'h1234;
    bus.load  = 1'b1;
    tick("load_1234");
    bus.load  = 1'b0;
    bus.value = 16'hFFFF;
    run_frame("frame_1234");
    check_frame("dec_1234", 7'h4C, 7'h06, 7'h12, 7'h4F);
    for (int d = 0; d < DIGITS; d++) check("lit_cycles", 32'(lit_cnt[d]), 32'(REFRESH_DIV - GUARD));
    check("dark_cycles", 32'(dark_cnt), 32'(DIGITS * GUARD));

    // 3. AB0F in hex then decimal, with decimal points requested.
    bus.value    = 16'hAB0F;
    bus.load     = 1'b1;
    bus.hex_mode = 1'b1;
    bus.dp       = 4'b0101;
    tick("load_ab0f");
    bus.load     = 1'b0;
    run_frame("frame_hex");
    check_frame("hex_ab0f", 7'h38, 7'h01, 7'h60, 7'h08);
    bus.hex_mode = 1'b0;
    run_frame("frame_dec");
    check_frame("dec_ab0f", 7'h7F, 7'h01, 7'h7F, 7'h7F);
    bus.dp       = 4'h0;

    // 4. Blank mid-slot, then resume in place.
    while (m_cnt != 4) tick("seek_blank");
    bus.blank = 1'b1;
    tick("blank_on");
    check("blank_an", 32'(bus.an), 32'h0F);
    check("blank_seg", 32'(bus.seg), 32'h7F);
    tick("blank_hold1");
    tick("blank_hold2");
    bus.blank = 1'b0;
    for (int i = 0; i < REFRESH_DIV; i++) tick("blank_resume");

    // 5. Load at the slot's last cycle; next slot must show the new glyph.
    while (m_cnt != REFRESH_DIV - 1) tick("seek_slot_end");
    bus.value = 16'h5555;
    bus.load  = 1'b1;
    tick("load_at_wrap");
    bus.load  = 1'b0;
    for (int i = 0; i < REFRESH_DIV; i++) begin
      tick("slot_after_load");
      if (bus.an != 4'hF) check("new_glyph_5", 32'(bus.seg), 32'h24);
    end

    // Reset mid-scan together with load: reset wins, shadow clears.
    while (m_cnt != 5) tick("seek_reset");
    reset     = 1'b1;
    bus.load  = 1'b1;
    bus.value = 16'h9999;
    tick("reset_mid");
    check("reset_mid_an", 32'(bus.an), 32'h0F);
    check("reset_mid_seg", 32'(bus.seg), 32'h7F);
    reset     = 1'b0;
    bus.load  = 1'b0;
    tick("reset_g1");
    tick("reset_g2");
    tick("reset_lit");
    check("reset_lit_an", 32'(bus.an), 32'h0E);
    check("reset_shadow_seg", 32'(bus.seg), 32'h01);

    // 6. Leading zeros (suppressed only when the feature is built in).
    bus.dp    = 4'b1010;
    bus.value = 16'h0070;
    bus.load  = 1'b1;
    tick("load_0070");
    bus.load  = 1'b0;
    run_frame("frame_0070");
`ifdef SEVSEG_LZS_EN
    check_frame("lz_0070", 7'h01, 7'h0F, 7'h7F, 7'h7F);
`else
    check_frame("lz_0070", 7'h01, 7'h0F, 7'h01, 7'h01);
`endif
    bus.value = 16'h0000;
    bus.load  = 1'b1;
    tick("load_0000");
    bus.load  = 1'b0;
    run_frame("frame_0000");
`ifdef SEVSEG_LZS_EN
    check_frame("lz_0000", 7'h01, 7'h7F, 7'h7F, 7'h7F);
`else
    check_frame("lz_0000", 7'h01, 7'h01, 7'h01, 7'h01);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
